// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side pipeline signals of the decode stage.
// slave is the decode stage's view; master is the surrounding pipeline's view.
interface decode_stage_if #(
  parameter int XLEN  = 32,
  parameter int RADDR = 5
);
  // Handshake: a transfer happens on a rising edge where valid && ready.
  // valid must not depend combinationally on ready; payload is sampled only on transfer.
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [XLEN-1:0]  in_pc;

  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_pc;
  logic [XLEN-1:0]  out_rs1_val;
  logic [XLEN-1:0]  out_rs2_val;
  logic [XLEN-1:0]  out_imm;
  logic [RADDR-1:0] out_rs1;
  logic [RADDR-1:0] out_rs2;
  logic [RADDR-1:0] out_rd;
  logic [6:0]       out_opcode;
  logic [2:0]       out_funct3;
  logic             out_funct7b5;
  logic             out_rd_we;
  logic             out_illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_rs1_val, out_rs2_val, out_imm,
           out_rs1, out_rs2, out_rd, out_opcode, out_funct3, out_funct7b5,
           out_rd_we, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_rs1_val, out_rs2_val, out_imm,
           out_rs1, out_rs2, out_rd, out_opcode, out_funct3, out_funct7b5,
           out_rd_we, out_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode / register-read stage: immediate and control decode, write-back
// bypass into the operands, and a one-entry ID/EX register toward execute.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int RADDR = 5
) (
  input  logic             Clk,
  input  logic             reset,
  decode_stage_if.slave    pipe,
  output logic [RADDR-1:0] RegA,
  output logic [RADDR-1:0] RegB,
  input  logic [XLEN-1:0]  dataA,
  input  logic [XLEN-1:0]  dataB,
  input  logic             wb_en,
  input  logic [RADDR-1:0] wb_reg,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             flush
);

  logic [31:0]      ins;
  logic [6:0]       opcode;
  logic [RADDR-1:0] rd;
  logic [31:0]      imm32;
  logic             known;
  logic             writes;
  logic             illegal;
  logic             dec_rd_we;
  logic [XLEN-1:0]  dec_imm;
  logic [XLEN-1:0]  rs1_val;
  logic [XLEN-1:0]  rs2_val;
  logic             capture;

  assign ins    = pipe.in_instr;
  assign opcode = ins[6:0];
  assign rd     = ins[7+RADDR-1:7];
  assign RegA   = ins[15+RADDR-1:15];
  assign RegB   = ins[20+RADDR-1:20];

  assign pipe.in_ready = !pipe.out_valid || pipe.out_ready;
  assign capture       = pipe.in_valid && pipe.in_ready && !flush;

  always_comb begin
    imm32  = 32'h0;
    known  = 1'b1;
    writes = 1'b0;
    case (opcode)
      7'b0010011, 7'b0000011, 7'b1100111: begin
        imm32  = {{20{ins[31]}}, ins[31:20]};
        writes = 1'b1;
      end
      7'b0100011: imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      7'b1100011: imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      7'b0110111, 7'b0010111: begin
        imm32  = {ins[31:12], 12'b0};
        writes = 1'b1;
      end
      7'b1101111: begin
        imm32  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        writes = 1'b1;
      end
      7'b0110011: writes = 1'b1;
      7'b1110011: writes = 1'b0;
      default:    known  = 1'b0;
    endcase
  end

  // Illegal entries still flow downstream, but must never write or carry an immediate.
  assign illegal   = (ins[1:0] != 2'b11) || !known;
  assign dec_rd_we = writes && !illegal && (rd != '0);
  assign dec_imm   = illegal ? '0 : {{(XLEN-31){imm32[31]}}, imm32[30:0]};

  // Register-file writes on this edge are not yet visible on dataA/dataB.
  assign rs1_val = (wb_en && wb_reg == RegA && RegA != '0) ? wb_data : dataA;
  assign rs2_val = (wb_en && wb_reg == RegB && RegB != '0) ? wb_data : dataB;

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      pipe.out_valid    <= 1'b0;
      pipe.out_pc       <= '0;
      pipe.out_rs1_val  <= '0;
      pipe.out_rs2_val  <= '0;
      pipe.out_imm      <= '0;
      pipe.out_rs1      <= '0;
      pipe.out_rs2      <= '0;
      pipe.out_rd       <= '0;
      pipe.out_opcode   <= '0;
      pipe.out_funct3   <= '0;
      pipe.out_funct7b5 <= 1'b0;
      pipe.out_rd_we    <= 1'b0;
      pipe.out_illegal  <= 1'b0;
    end else if (flush) begin
      pipe.out_valid <= 1'b0;
    end else if (capture) begin
      pipe.out_valid    <= 1'b1;
      pipe.out_pc       <= pipe.in_pc;
      pipe.out_rs1_val  <= rs1_val;
      pipe.out_rs2_val  <= rs2_val;
      pipe.out_imm      <= dec_imm;
      pipe.out_rs1      <= RegA;
      pipe.out_rs2      <= RegB;
      pipe.out_rd       <= rd;
      pipe.out_opcode   <= opcode;
      pipe.out_funct3   <= ins[14:12];
      pipe.out_funct7b5 <= ins[30];
      pipe.out_rd_we    <= dec_rd_we;
      pipe.out_illegal  <= illegal;
    end else if (pipe.out_valid && pipe.out_ready) begin
      pipe.out_valid <= 1'b0;
    end else if (pipe.out_valid && wb_en && wb_reg != '0) begin
      // Held entry: keep operands coherent with writes retiring behind it.
      if (wb_reg == pipe.out_rs1) pipe.out_rs1_val <= wb_data;
      if (wb_reg == pipe.out_rs2) pipe.out_rs2_val <= wb_data;
    end
  end

endmodule
